// File: rtl/apb_pkg.sv
// Shared APB master types and constants: FSM states, slave slot indices and
// the default APB window base address.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_t;

    localparam int NUM_SLAVES = 4;

    localparam int SLV_GPO  = 0;
    localparam int SLV_GPI  = 1;
    localparam int SLV_TMR  = 2;
    localparam int SLV_UART = 3;

    localparam logic [31:0] APB_BASE_DEFAULT = 32'h1000_0000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB window decoder: a 16 KiB window split into four 4 KiB
// slave slots selected by addr[13:12].
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE = APB_BASE_DEFAULT
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel
);

    // Offset bits inside a slot play no part in slave selection.
    logic unused_offset;
    assign unused_offset = ^addr[11:0];

    always_comb begin
        hit = (addr[31:14] == APB_BASE[31:14]);
        sel = '0;
        if (hit) begin
            sel[addr[13:12]] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Two-port round-robin APB master: arbitrates CPU/DMA requests, decodes the
// slave slot and runs SETUP/ACCESS with a PREADY timeout.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] APB_BASE       = APB_BASE_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_t            state;
    logic                  grant;
    logic                  last_grant;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [NUM_SLAVES-1:0] sel_q;

    logic                  any_req;
    logic                  winner;
    logic [31:0]           win_addr;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  busy;
    logic                  done;

    // On a tie the port that was not served last wins; a lone request always wins.
    always_comb begin
        any_req  = req0 | req1;
        winner   = (req0 && req1) ? ~last_grant : (req1 & ~req0);
        win_addr = winner ? addr1 : addr0;
    end

    apb_addr_decoder #(
        .APB_BASE (APB_BASE)
    ) u_decoder (
        .addr (win_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Only the latched slave's response is observed; others are masked off.
    always_comb begin
        sel_ready = (sel_q[SLV_GPO]  & PREADY0) |
                    (sel_q[SLV_GPI]  & PREADY1) |
                    (sel_q[SLV_TMR]  & PREADY2) |
                    (sel_q[SLV_UART] & PREADY3);
        sel_rdata = ({32{sel_q[SLV_GPO]}}  & PRDATA0) |
                    ({32{sel_q[SLV_GPI]}}  & PRDATA1) |
                    ({32{sel_q[SLV_TMR]}}  & PRDATA2) |
                    ({32{sel_q[SLV_UART]}} & PRDATA3);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            sel_q      <= '0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        PADDR      <= win_addr;
                        PWDATA     <= winner ? wdata1 : wdata0;
                        PWRITE     <= winner ? we1 : we0;
                        sel_q      <= dec_sel;
                        tmo_cnt    <= '0;
                        if (dec_hit) begin
                            state <= ST_SETUP;
                        end else begin
                            state   <= ST_DONE;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A PREADY on the final allowed cycle still completes normally.
                    if (sel_ready) begin
                        rdata_q <= PWRITE ? 32'd0 : sel_rdata;
                        err_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state == ST_SETUP) || (state == ST_ACCESS);
        done    = (state == ST_DONE);
        PENABLE = (state == ST_ACCESS);
        {PSEL3, PSEL2, PSEL1, PSEL0} = busy ? sel_q : '0;
        ack0    = done & ~grant;
        ack1    = done & grant;
        rdata0  = ack0 ? rdata_q : '0;
        rdata1  = ack1 ? rdata_q : '0;
        err0    = ack0 & err_q;
        err1    = ack1 & err_q;
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: four behavioural APB slaves plus a transaction-level
// model of arbitration order, address decode and slave memory contents.
module tb_apb_master_arb;

    localparam int          TO      = 20;
    localparam logic [31:0] TB_BASE = 32'h1000_0000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arb #(
        .TIMEOUT_CYCLES (TO),
        .APB_BASE       (TB_BASE)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    // ---------------- behavioural slaves ----------------
    logic        mem_init;
    logic [3:0]  stall;
    int          wait_cfg [4];
    int          wcnt [4];
    logic [3:0]  pready_v;
    logic [31:0] smem [4][16];
    logic [3:0]  psel_v;

    function automatic logic [31:0] init_word(int s, int w);
        return 32'hA000_0000 + 32'(s * 256 + w);
    endfunction

    assign psel_v  = {PSEL3, PSEL2, PSEL1, PSEL0};
    assign PREADY0 = pready_v[0];
    assign PREADY1 = pready_v[1];
    assign PREADY2 = pready_v[2];
    assign PREADY3 = pready_v[3];
    assign PRDATA0 = smem[0][PADDR[5:2]];
    assign PRDATA1 = smem[1][PADDR[5:2]];
    assign PRDATA2 = smem[2][PADDR[5:2]];
    assign PRDATA3 = smem[3][PADDR[5:2]];

    // Registered PREADY: raised wait_cfg cycles after the first ACCESS edge.
    always @(posedge PCLK) begin
        for (int s = 0; s < 4; s++) begin
            if (mem_init) begin
                for (int w = 0; w < 16; w++) smem[s][w] <= init_word(s, w);
                pready_v[s] <= 1'b0;
                wcnt[s]     <= 0;
            end else if (psel_v[s] && PENABLE && !pready_v[s]) begin
                wcnt[s] <= wcnt[s] + 1;
                if (!stall[s] && wcnt[s] >= wait_cfg[s]) pready_v[s] <= 1'b1;
            end else begin
                if (psel_v[s] && PENABLE && pready_v[s] && PWRITE)
                    smem[s][PADDR[5:2]] <= PWDATA;
                wcnt[s]     <= 0;
                pready_v[s] <= 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] m_mem [int];
    int          m_last;

    function automatic int m_key(logic [31:0] a);
        return int'({a[13:12], a[5:2]});
    endfunction

    function automatic int m_pick(bit p0, bit p1);
        int w;
        if (p0 && p1) w = (m_last == 0) ? 1 : 0;
        else          w = p0 ? 0 : 1;
        m_last = w;
        return w;
    endfunction

    task automatic m_apply(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] exp_rd, output logic exp_er);
        int k;
        k = m_key(a);
        if (a[31:14] != TB_BASE[31:14]) begin
            exp_rd = 32'd0;
            exp_er = 1'b1;
        end else if (we) begin
            m_mem[k] = d;
            exp_rd   = 32'd0;
            exp_er   = 1'b0;
        end else begin
            exp_rd = m_mem.exists(k) ? m_mem[k] : init_word(int'(a[13:12]), int'(a[5:2]));
            exp_er = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_port(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(posedge PCLK); #1;
        PRESET = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        m_last = 1;
    endtask

    // Waits for any ack, returns at the negedge of the DONE cycle and drops that req.
    task automatic wait_ack(input int limit, output int port, output logic [31:0] rd,
                            output logic er, output int cycles, output logic [33:0] oth);
        port = -1; rd = '0; er = 1'b0; cycles = -1; oth = '0;
        for (int c = 0; c < limit; c++) begin
            @(negedge PCLK);
            if (ack0 || ack1) begin
                port   = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                rd     = ack1 ? rdata1 : rdata0;
                er     = ack1 ? err1 : err0;
                oth    = ack1 ? {ack0, err0, rdata0} : {ack1, err1, rdata1};
                cycles = c;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge PCLK);
        checks++;
        if ({PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE} !== 6'b0) begin
            errors++; $display("FAIL reset_apb_ctrl: got %b expected 000000", {PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE});
        end
        checks++;
        if ({PADDR, PWDATA} !== 64'd0) begin
            errors++; $display("FAIL reset_paddr_pwdata: got %h %h expected 0 0", PADDR, PWDATA);
        end
        checks++;
        if ({ack0, ack1, err0, err1} !== 4'b0) begin
            errors++; $display("FAIL reset_ack_err: got %b expected 0000", {ack0, ack1, err0, err1});
        end
        checks++;
        if ({rdata0, rdata1} !== 64'd0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0, rdata1);
        end
    endtask

    task automatic test_single_write();
        logic [31:0] erd; logic eer; int w;
        @(posedge PCLK); #1;
        drive_port(0, 1'b1, 32'h1000_0004, 32'h0000_00FF);
        w = m_pick(1, 0);
        m_apply(1'b1, 32'h1000_0004, 32'h0000_00FF, erd, eer);
        for (int c = 0; c < 6; c++) begin
            @(negedge PCLK);
            checks++;
            if ({PSEL3, PSEL2, PSEL1, PSEL0} !== ((c >= 1 && c <= 3) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL wr_psel c%0d: got %b expected %b", c, {PSEL3, PSEL2, PSEL1, PSEL0}, (c >= 1 && c <= 3) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (PENABLE !== (c >= 2 && c <= 3)) begin
                errors++; $display("FAIL wr_penable c%0d: got %b expected %b", c, PENABLE, (c >= 2 && c <= 3));
            end
            checks++;
            if (ack0 !== (c == 4 && w == 0)) begin
                errors++; $display("FAIL wr_ack0 c%0d: got %b expected %b", c, ack0, (c == 4));
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({PWRITE, PWDATA, PADDR} !== {1'b1, 32'h0000_00FF, 32'h1000_0004}) begin
                    errors++; $display("FAIL wr_bus_hold c%0d: got %b %h %h expected 1 000000ff 10000004", c, PWRITE, PWDATA, PADDR);
                end
            end
            if (c == 4) begin
                checks++;
                if ({err0, rdata0} !== {eer, erd}) begin
                    errors++; $display("FAIL wr_err0: got %b %h expected %b %h", err0, rdata0, eer, erd);
                end
            end
            if (ack0) req0 = 1'b0;
        end
        req0 = 1'b0;
        checks++;
        if (smem[0][1] !== 32'h0000_00FF) begin
            errors++; $display("FAIL wr_slave_reg1: got %h expected 000000ff", smem[0][1]);
        end
    endtask

    task automatic test_read();
        int port, cyc, w; logic [31:0] rd, erd; logic er, eer; logic [33:0] oth;
        @(posedge PCLK); #1;
        drive_port(1, 1'b0, 32'h1000_0004, 32'd0);
        w = m_pick(0, 1);
        m_apply(1'b0, 32'h1000_0004, 32'd0, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if (port !== w) begin
            errors++; $display("FAIL rd_port: got %0d expected %0d", port, w);
        end
        checks++;
        if ({er, rd} !== {eer, erd}) begin
            errors++; $display("FAIL rd_data: got err %b data %h expected err %b data %h", er, rd, eer, erd);
        end
        checks++;
        if (oth !== 34'd0) begin
            errors++; $display("FAIL rd_other_port: got %h expected 0", oth);
        end
        checks++;
        if (cyc !== 4) begin
            errors++; $display("FAIL rd_latency: got %0d expected 4", cyc);
        end
    endtask

    task automatic test_miss();
        int port, cyc, w; logic [31:0] rd, erd; logic er, eer; logic [33:0] oth;
        logic [31:0] bnd [3];
        bnd[0] = 32'h1000_4000; bnd[1] = 32'h0FFF_FFFC; bnd[2] = 32'h1000_3FFC;
        @(posedge PCLK); #1;
        drive_port(0, 1'b0, 32'h2000_0000, 32'd0);
        w = m_pick(1, 0);
        m_apply(1'b0, 32'h2000_0000, 32'd0, erd, eer);
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            checks++;
            if ({PSEL3, PSEL2, PSEL1, PSEL0, PENABLE} !== 5'b0) begin
                errors++; $display("FAIL miss_no_psel c%0d: got %b expected 00000", c, {PSEL3, PSEL2, PSEL1, PSEL0, PENABLE});
            end
            if (c == 1) begin
                checks++;
                if ({ack0, err0, rdata0} !== {1'b1, eer, erd}) begin
                    errors++; $display("FAIL miss_ack: got ack %b err %b data %h expected ack 1 err %b data %h", ack0, err0, rdata0, eer, erd);
                end
            end
            if (ack0) req0 = 1'b0;
        end
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            drive_port(0, 1'b0, bnd[i], 32'd0);
            w = m_pick(1, 0);
            m_apply(1'b0, bnd[i], 32'd0, erd, eer);
            wait_ack(40, port, rd, er, cyc, oth);
            checks++;
            if ({port == w, er, rd} !== {1'b1, eer, erd}) begin
                errors++; $display("FAIL boundary_%h: got port %0d err %b data %h expected port %0d err %b data %h", bnd[i], port, er, rd, w, eer, erd);
            end
            checks++;
            if (cyc !== (eer ? 1 : 4)) begin
                errors++; $display("FAIL boundary_lat_%h: got %0d expected %0d", bnd[i], cyc, eer ? 1 : 4);
            end
        end
    endtask

    task automatic test_timeout();
        int port, cyc, w; logic [31:0] rd; logic er; logic [33:0] oth;
        stall[2] = 1'b1;
        @(posedge PCLK); #1;
        drive_port(0, 1'b0, 32'h1000_2008, 32'd0);
        w = m_pick(1, 0);
        wait_ack(TO + 30, port, rd, er, cyc, oth);
        checks++;
        if ({port == w, er, rd} !== {1'b1, 1'b1, 32'd0}) begin
            errors++; $display("FAIL timeout_resp: got port %0d err %b data %h expected port %0d err 1 data 0", port, er, rd, w);
        end
        checks++;
        if (cyc !== TO + 2) begin
            errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, TO + 2);
        end
        checks++;
        if ({PSEL2, PENABLE} !== 2'b00) begin
            errors++; $display("FAIL timeout_psel_drop: got %b expected 00", {PSEL2, PENABLE});
        end
        req0 = 1'b0;
        stall[2] = 1'b0;
    endtask

    task automatic test_tie();
        int port, cyc, w; logic [31:0] rd, erd; logic er, eer; logic [33:0] oth;
        logic [31:0] d1;
        d1 = $urandom;
        apply_reset();
        @(posedge PCLK); #1;
        drive_port(0, 1'b0, 32'h1000_1000, 32'd0);
        drive_port(1, 1'b1, 32'h1000_3004, d1);
        w = m_pick(1, 1);
        m_apply(1'b0, 32'h1000_1000, 32'd0, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if (port !== w) begin
            errors++; $display("FAIL tie1_winner: got %0d expected %0d", port, w);
        end
        checks++;
        if ({er, rd} !== {eer, erd}) begin
            errors++; $display("FAIL tie1_data: got %b %h expected %b %h", er, rd, eer, erd);
        end
        // Port 0 re-requests straight away while port 1 is still waiting.
        drive_port(0, 1'b1, 32'h1000_3004, 32'h5A5A_0001);
        w = m_pick(1, 1);
        m_apply(1'b1, 32'h1000_3004, d1, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if (port !== w) begin
            errors++; $display("FAIL tie2_winner: got %0d expected %0d", port, w);
        end
        w = m_pick(1, 0);
        m_apply(1'b1, 32'h1000_3004, 32'h5A5A_0001, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if (port !== w) begin
            errors++; $display("FAIL tie3_winner: got %0d expected %0d", port, w);
        end
        @(posedge PCLK); #1;
        drive_port(1, 1'b0, 32'h1000_3004, 32'd0);
        w = m_pick(0, 1);
        m_apply(1'b0, 32'h1000_3004, 32'd0, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if ({port == w, er, rd} !== {1'b1, eer, erd}) begin
            errors++; $display("FAIL tie_readback: got port %0d err %b data %h expected port %0d err %b data %h", port, er, rd, w, eer, erd);
        end
    endtask

    task automatic test_reset_mid();
        int port, cyc, w; logic [31:0] rd, erd; logic er, eer; logic [33:0] oth;
        @(posedge PCLK); #1;
        drive_port(0, 1'b0, 32'h1000_3008, 32'd0);
        repeat (3) @(negedge PCLK);
        checks++;
        if ({PSEL3, PENABLE} !== 2'b11) begin
            errors++; $display("FAIL rstmid_in_access: got %b expected 11", {PSEL3, PENABLE});
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE, ack0, ack1} !== 8'b0 || PADDR !== 32'd0) begin
            errors++; $display("FAIL rstmid_outputs: got %b paddr %h expected 00000000 paddr 0", {PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE, ack0, ack1}, PADDR);
        end
        PRESET = 1'b0;
        m_last = 1;
        w = m_pick(1, 0);
        m_apply(1'b0, 32'h1000_3008, 32'd0, erd, eer);
        wait_ack(40, port, rd, er, cyc, oth);
        checks++;
        if ({port == w, er, rd} !== {1'b1, eer, erd}) begin
            errors++; $display("FAIL rstmid_reserve: got port %0d err %b data %h expected port %0d err %b data %h", port, er, rd, w, eer, erd);
        end
    endtask

    logic        r_we   [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    bit          pend   [2];

    task automatic start_random(input int p);
        int r;
        r = $urandom_range(0, 9);
        r_we[p]   = 1'($urandom_range(0, 1));
        r_data[p] = $urandom;
        if (r == 0) r_addr[p] = 32'h2000_0000 + 32'($urandom_range(0, 15) << 2);
        else        r_addr[p] = TB_BASE + 32'($urandom_range(0, 3) << 12) + 32'($urandom_range(0, 3) << 2);
        drive_port(p, r_we[p], r_addr[p], r_data[p]);
        pend[p] = 1'b1;
    endtask

    task automatic test_random();
        int budget, port, cyc, w, pat; logic [31:0] rd, erd; logic er, eer; logic [33:0] oth;
        budget = 40;
        pend[0] = 1'b0; pend[1] = 1'b0;
        while (budget > 0 || pend[0] || pend[1]) begin
            if (!pend[0] && !pend[1]) begin
                @(posedge PCLK); #1;
                for (int s = 0; s < 4; s++) wait_cfg[s] = $urandom_range(0, 2);
                pat = $urandom_range(1, 3);
                if (pat[0]) begin start_random(0); budget--; end
                if (pat[1] && budget > 0) begin start_random(1); budget--; end
            end
            w = m_pick(pend[0], pend[1]);
            m_apply(r_we[w], r_addr[w], r_data[w], erd, eer);
            wait_ack(60, port, rd, er, cyc, oth);
            checks++;
            if (port !== w) begin
                errors++; $display("FAIL rand_winner: got %0d expected %0d addr %h", port, w, r_addr[w]);
                req0 = 1'b0; req1 = 1'b0;
                break;
            end
            checks++;
            if ({er, rd} !== {eer, erd}) begin
                errors++; $display("FAIL rand_resp addr %h we %b: got err %b data %h expected err %b data %h", r_addr[w], r_we[w], er, rd, eer, erd);
            end
            checks++;
            if (oth !== 34'd0) begin
                errors++; $display("FAIL rand_other_port: got %h expected 0", oth);
            end
            pend[w] = 1'b0;
            if (budget > 0 && $urandom_range(0, 1) == 1) begin
                start_random(w);
                budget--;
            end
        end
        for (int s = 0; s < 4; s++) wait_cfg[s] = 0;
    endtask

    initial begin
        PRESET = 1'b1; mem_init = 1'b1; stall = 4'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int s = 0; s < 4; s++) wait_cfg[s] = 0;
        m_last = 1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0; mem_init = 1'b0;

        test_reset();
        test_single_write();
        test_read();
        test_miss();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
